// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and parameter-check helper for the
// sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Smallest width that can hold 10^n - 1, i.e. ceil(log2(10^n)).
  function automatic int min_bin_w(input int n);
    longint unsigned p;
    int              w;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    w = 64;
    for (int b = 63; b >= 0; b--) begin
      if ((64'd1 << b) >= p) w = b;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_bin_seq_if.sv
// Input and output valid/ready streams of the BCD-to-binary converter.
// The master side produces words and consumes results; the slave is the converter.
interface bcd_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) ();
  import bcd_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd;
  logic                          out_valid;
  logic                          out_ready;
  logic [BIN_W-1:0]              out_bin;
  logic                          out_illegal;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_illegal
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_illegal
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// One multiply-by-10-and-add step of the conversion, plus a check
// for a nibble that is not a decimal digit.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BIN_W-1:0]       acc_next,
  output logic                   d_illegal
);

  // acc*10 as (acc*8 + acc*2); the sum wraps modulo 2^BIN_W by design.
  assign acc_next  = (acc << 3) + (acc << 1) + BIN_W'(d);
  assign d_illegal = (d > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first,
// with valid/ready handshakes on both the input and result side.
module bcd_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_bin_seq_if.slave   bus,
  output logic           busy
);

  localparam int SR_W  = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  generate
    if (DIGITS < 1) begin : g_bad_digits
      $error("bcd_bin_seq: DIGITS must be at least 1");
    end
    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
      $error("bcd_bin_seq: BIN_W too narrow for DIGITS");
    end
  endgenerate

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SR_W-1:0]        sr;
  logic [BIN_W-1:0]       acc;
  logic                   illegal;
  logic [BCD_DIGIT_W-1:0] d;
  logic [BIN_W-1:0]       acc_next;
  logic                   d_illegal;

  assign d = sr[SR_W-1 -: BCD_DIGIT_W];

  bcd_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc       (acc),
    .d         (d),
    .acc_next  (acc_next),
    .d_illegal (d_illegal)
  );

  // The word is latched on acceptance, so later in_bcd changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sr      <= '0;
      acc     <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sr      <= bus.in_bcd;
            acc     <= '0;
            cnt     <= '0;
            illegal <= 1'b0;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          acc     <= acc_next;
          illegal <= illegal | d_illegal;
          sr      <= sr << BCD_DIGIT_W;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Results come straight from the accumulator, which is frozen in DONE.
  assign bus.in_ready    = (state == ST_IDLE);
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.out_bin     = acc;
  assign bus.out_illegal = illegal;
  assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Scoreboard bench for bcd_bin_seq: a 4-digit instance for the main scenarios
// plus 6-digit and 1-digit instances for the parameter sweep.
module tb_bcd_bin_seq;
  import bcd_pkg::*;

  typedef struct {
    logic [31:0] bin;
    logic        illegal;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy4, busy6, busy1;
  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  bcd_bin_seq_if #(.DIGITS(4), .BIN_W(14)) if4 ();
  bcd_bin_seq_if #(.DIGITS(6), .BIN_W(20)) if6 ();
  bcd_bin_seq_if #(.DIGITS(1), .BIN_W(4))  if1 ();

  bcd_bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4), .busy(busy4));
  bcd_bin_seq #(.DIGITS(6), .BIN_W(20)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6), .busy(busy6));
  bcd_bin_seq #(.DIGITS(1), .BIN_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));

  always #5 clk = ~clk;

  // Decimal reference: digit-wise value, wrapped to the result width.
  function automatic exp_t model(input logic [31:0] bcd, input int digits, input int w);
    exp_t        e;
    logic [3:0]  nib;
    logic [31:0] sh;
    e.bin     = 32'd0;
    e.illegal = 1'b0;
    for (int k = digits - 1; k >= 0; k--) begin
      sh        = bcd >> (4 * k);
      nib       = sh[3:0];
      e.bin     = e.bin * 10 + 32'(nib);
      e.illegal = e.illegal | (nib > 4'd9);
    end
    e.bin = e.bin & ((32'd1 << w) - 32'd1);
    return e;
  endfunction

  task automatic send4(input logic [15:0] w);
    if4.in_bcd   = w;
    if4.in_valid = 1'b1;
    for (int i = 0; i < 20 && !if4.in_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.in_bcd   = 16'($urandom);
    q.push_back(model(32'(w), 4, 14));
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (!if4.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (5) begin
      if4.in_valid  = 1'($urandom);
      if4.in_bcd    = 16'($urandom);
      if4.out_ready = 1'($urandom);
      @(posedge clk); #1;
      n_vec++;
      if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1 || busy4 !== 1'b0 || if4.out_bin !== 14'd0) begin
        n_bad++;
        $display("[TB] FAIL reset_hold got valid=%b ready=%b busy=%b bin=%0d exp valid=0 ready=1 busy=0 bin=0",
                 if4.out_valid, if4.in_ready, busy4, if4.out_bin);
      end
    end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_vec++;
      if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1 || busy4 !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_release got valid=%b ready=%b busy=%b exp 0/1/0",
                 if4.out_valid, if4.in_ready, busy4);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] words [3];
    exp_t e;
    int   lat;
    words = '{16'h1234, 16'h9999, 16'h0000};
    if4.out_ready = 1'b1;
    foreach (words[i]) begin
      send4(words[i]);
      wait4(lat);
      e = q.pop_front();
      n_vec++;
      if (lat !== 4) begin
        n_bad++;
        $display("[TB] FAIL basic_latency word=%h got=%0d exp=4", words[i], lat);
      end
      n_vec++;
      if (if4.out_bin !== e.bin[13:0] || if4.out_illegal !== e.illegal) begin
        n_bad++;
        $display("[TB] FAIL basic_result word=%h got=%0d/%b exp=%0d/%b",
                 words[i], if4.out_bin, if4.out_illegal, e.bin, e.illegal);
      end
      @(posedge clk); #1;
      n_vec++;
      if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL basic_return got ready=%b valid=%b exp ready=1 valid=0",
                 if4.in_ready, if4.out_valid);
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] words [3];
    exp_t e;
    int   lat;
    words = '{16'h12A4, 16'h0007, 16'hFFFF};
    if4.out_ready = 1'b1;
    foreach (words[i]) begin
      send4(words[i]);
      wait4(lat);
      e = q.pop_front();
      n_vec++;
      if (lat !== 4) begin
        n_bad++;
        $display("[TB] FAIL illegal_latency word=%h got=%0d exp=4", words[i], lat);
      end
      n_vec++;
      if (if4.out_bin !== e.bin[13:0]) begin
        n_bad++;
        $display("[TB] FAIL illegal_bin word=%h got=%0d exp=%0d", words[i], if4.out_bin, e.bin);
      end
      n_vec++;
      if (if4.out_illegal !== e.illegal) begin
        n_bad++;
        $display("[TB] FAIL illegal_flag word=%h got=%b exp=%b", words[i], if4.out_illegal, e.illegal);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    if4.out_ready = 1'b0;
    send4(16'h0500);
    wait4(lat);
    e = q.pop_front();
    n_vec++;
    if (lat !== 4) begin
      n_bad++;
      $display("[TB] FAIL stall_latency got=%0d exp=4", lat);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        if4.in_valid = 1'b1;
        if4.in_bcd   = 16'h0001;
      end
      if (c == 4) if4.in_valid = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (if4.out_valid !== 1'b1 || if4.in_ready !== 1'b0 || if4.out_bin !== e.bin[13:0] ||
          if4.out_illegal !== e.illegal) begin
        n_bad++;
        $display("[TB] FAIL stall_hold cyc=%0d got valid=%b ready=%b bin=%0d exp valid=1 ready=0 bin=%0d",
                 c, if4.out_valid, if4.in_ready, if4.out_bin, e.bin);
      end
    end
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL stall_release got valid=%b ready=%b exp 0/1", if4.out_valid, if4.in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy4 !== 1'b0 || if4.out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL stall_ignored got busy=%b valid=%b exp 0/0", busy4, if4.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    bit   seen;
    seen = 1'b0;
    if4.out_ready = 1'b1;
    send4(16'h8888);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL abort_now got ready=%b valid=%b busy=%b exp 1/0/0",
               if4.in_ready, if4.out_valid, busy4);
    end
    q.delete();
    repeat (6) begin
      @(posedge clk); #1;
      if (if4.out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL abort_valid got=%b exp=0", seen);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send4(16'h0042);
    wait4(lat);
    e = q.pop_front();
    n_vec++;
    if (lat !== 4 || if4.out_bin !== e.bin[13:0] || if4.out_illegal !== e.illegal) begin
      n_bad++;
      $display("[TB] FAIL abort_next got lat=%0d bin=%0d ill=%b exp lat=4 bin=%0d ill=%b",
               lat, if4.out_bin, if4.out_illegal, e.bin, e.illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    logic [3:0] ones [2];
    exp_t e;
    int   lat;
    if6.in_bcd   = 24'h999999;
    if6.in_valid = 1'b1;
    @(posedge clk); #1;
    if6.in_valid = 1'b0;
    if6.in_bcd   = 24'h123456;
    q.push_back(model(32'h0099_9999, 6, 20));
    lat = 0;
    while (!if6.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    e = q.pop_front();
    n_vec++;
    if (lat !== 6 || if6.out_bin !== e.bin[19:0] || if6.out_illegal !== e.illegal) begin
      n_bad++;
      $display("[TB] FAIL sweep6 got lat=%0d bin=%0d ill=%b exp lat=6 bin=%0d ill=%b",
               lat, if6.out_bin, if6.out_illegal, e.bin, e.illegal);
    end
    @(posedge clk); #1;

    ones = '{4'h9, 4'hC};
    foreach (ones[i]) begin
      if1.in_bcd   = ones[i];
      if1.in_valid = 1'b1;
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      if1.in_bcd   = 4'h0;
      q.push_back(model(32'(ones[i]), 1, 4));
      lat = 0;
      while (!if1.out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      e = q.pop_front();
      n_vec++;
      if (lat !== 1 || if1.out_bin !== e.bin[3:0] || if1.out_illegal !== e.illegal) begin
        n_bad++;
        $display("[TB] FAIL sweep1 digit=%h got lat=%0d bin=%0d ill=%b exp lat=1 bin=%0d ill=%b",
                 ones[i], lat, if1.out_bin, if1.out_illegal, e.bin, e.illegal);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of run");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    if4.in_valid = 1'b0; if4.in_bcd = '0; if4.out_ready = 1'b1;
    if6.in_valid = 1'b0; if6.in_bcd = '0; if6.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_bcd = '0; if1.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
